// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sizes and state encoding for the CNN layer-4 drain path.
//   L4_LANES / L4_BANKS : result-RAM geometry of layer 4 (16 lanes x 4 addresses)
//   ACC_W / DATA_W      : accumulator width and scaled output width
//   drain_state_t       : drain FSM states
package cnn_pkg;

  localparam int L4_LANES = 16;
  localparam int L4_BANKS = 4;
  localparam int ACC_W    = 36;
  localparam int DATA_W   = 18;
  localparam int LANE_W   = $clog2(L4_LANES);
  localparam int BANK_W   = $clog2(L4_BANKS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    DONE
  } drain_state_t;

endpackage

// File: rtl/l4_sat.sv
// l4_sat: combinational rescale of one layer-4 accumulator.
//   i_acc : 36-bit signed accumulator from the result RAM
//   o_q   : 18-bit signed value = clamp(i_acc >>> SHIFT, 0, 131071)
module l4_sat
  import cnn_pkg::*;
#(
  parameter int SHIFT = 8
) (
  input  logic [ACC_W-1:0]  i_acc,
  output logic [DATA_W-1:0] o_q
);

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic signed [ACC_W-1:0] w_shift;

  assign w_shift = $signed(i_acc) >>> SHIFT;

  always_comb begin
    o_q = w_shift[DATA_W-1:0];
    // Negative results should not survive the ReLU; clamp them to zero anyway.
    if (w_shift[ACC_W-1]) begin
      o_q = '0;
    // Any set bit above the 17-bit magnitude means the value exceeds 131071.
    end else if (|w_shift[ACC_W-2:DATA_W-1]) begin
      o_q = MAX_POS;
    end
  end

endmodule

// File: rtl/l4_drain.sv
// l4_drain: streams the 64 layer-4 results (16 lanes x 4 banks) to the next
// FC layer, one scaled 18-bit word per valid/ready transfer, then pulses
// o_tx_done so layer 4 can reset for the next image.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_strt       : one-cycle start pulse (ignored unless idle)
//   o_addr_rd    : result-RAM bank address, shared by all lanes
//   i_din        : 16 lane read words, one cycle after o_addr_rd
//   o_dout/o_vld : scaled output word and its valid
//   i_rdy        : downstream ready
//   o_tx_done    : one-cycle pulse after the 64th transfer
//   o_busy       : high whenever the FSM is not idle
module l4_drain
  import cnn_pkg::*;
#(
  parameter int SHIFT = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_strt,
  output logic [BANK_W-1:0]                o_addr_rd,
  input  logic [L4_LANES-1:0][ACC_W-1:0]   i_din,
  output logic [DATA_W-1:0]                o_dout,
  output logic                             o_vld,
  input  logic                             i_rdy,
  output logic                             o_tx_done,
  output logic                             o_busy
);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(L4_LANES - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(L4_BANKS - 1);

  drain_state_t      r_state;
  logic [BANK_W-1:0] r_bank;
  logic [LANE_W-1:0] r_lane;
  logic [BANK_W-1:0] r_addr_rd;
  logic [DATA_W-1:0] r_dout;
  logic              r_vld;
  logic              r_tx_done;
  logic              r_busy;
  logic [DATA_W-1:0] r_hold [L4_LANES];

  logic [DATA_W-1:0] w_sat [L4_LANES];
  logic [LANE_W-1:0] w_lane_inc;
  logic [BANK_W-1:0] w_bank_inc;

  assign w_lane_inc = r_lane + 1'b1;
  assign w_bank_inc = r_bank + 1'b1;

  // Scaling happens in front of the holding register, so SEND only muxes.
  genvar gi;
  generate
    for (gi = 0; gi < L4_LANES; gi++) begin : g_sat
      l4_sat #(.SHIFT(SHIFT)) u_sat (
        .i_acc (i_din[gi]),
        .o_q   (w_sat[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bank    <= '0;
      r_lane    <= '0;
      r_addr_rd <= '0;
      r_dout    <= '0;
      r_vld     <= 1'b0;
      r_tx_done <= 1'b0;
      r_busy    <= 1'b0;
      for (int i = 0; i < L4_LANES; i++) r_hold[i] <= '0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_bank <= '0;
          if (i_strt) begin
            r_state   <= FETCH;
            r_addr_rd <= '0;
            r_busy    <= 1'b1;
          end
        end
        // Address is already presented; the RAM returns data during LOAD.
        FETCH: r_state <= LOAD;
        LOAD: begin
          r_hold  <= w_sat;
          r_lane  <= '0;
          r_dout  <= w_sat[0];
          r_vld   <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          if (i_rdy) begin
            if (r_lane != LANE_LAST) begin
              r_lane <= w_lane_inc;
              r_dout <= r_hold[w_lane_inc];
            end else begin
              r_vld <= 1'b0;
              if (r_bank != BANK_LAST) begin
                r_bank    <= w_bank_inc;
                r_addr_rd <= w_bank_inc;
                r_state   <= FETCH;
              end else begin
                r_tx_done <= 1'b1;
                r_state   <= DONE;
              end
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_addr_rd = r_addr_rd;
  assign o_dout    = r_dout;
  assign o_vld     = r_vld;
  assign o_tx_done = r_tx_done;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_l4_drain.sv
// tb_l4_drain: directed bench for l4_drain with a registered-read RAM model.
module tb_l4_drain;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               strt;
  logic [1:0]         addr_rd;
  logic [15:0][35:0]  din;
  logic [17:0]        dout;
  logic               vld;
  logic               rdy;
  logic               tx_done;
  logic               busy;

  logic [15:0][35:0]  mem [4];
  logic [17:0]        exp_v [64];

  logic [35:0] sat_in  [8] = '{36'h0_4000_0000, 36'hF_FFFF_FF00, 36'h0_01FF_FF00,
                               36'h0_0200_0000, 36'h0_0000_01FF, 36'h0_0000_00FF,
                               36'h8_0000_0000, 36'h7_FFFF_FFFF};
  logic [17:0] sat_exp [8] = '{18'h1FFFF, 18'h00000, 18'h1FFFF,
                               18'h1FFFF, 18'h00001, 18'h00000,
                               18'h00000, 18'h1FFFF};

  int n_vec;
  int n_err;
  int xfers, done_cyc, pulses, busy_cyc;

  always #5 clk = ~clk;

  l4_drain #(.SHIFT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_strt    (strt),
    .o_addr_rd (addr_rd),
    .i_din     (din),
    .o_dout    (dout),
    .o_vld     (vld),
    .i_rdy     (rdy),
    .o_tx_done (tx_done),
    .o_busy    (busy)
  );

  // Result RAM: registered read, one cycle latency.
  always @(posedge clk) din <= mem[addr_rd];

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_order();
    for (int b = 0; b < 4; b++)
      for (int l = 0; l < 16; l++) begin
        mem[b][l] = 36'((b * 16 + l) << 8);
        exp_v[b * 16 + l] = 18'(b * 16 + l);
      end
  endtask

  // Runs one image starting at a negedge. mode 0: rdy=1, mode 1: rdy 30 %.
  // abort_after > 0 asserts reset right after that many transfers.
  task automatic run_stream(input int mode, input int abort_after,
                            input int strt_a, input int strt_b,
                            output int n_x, output int d_cyc,
                            output int n_p, output int b_cyc);
    logic       prev_stall;
    logic [17:0] prev_dout;
    bit         finished;
    n_x = 0; d_cyc = -1; n_p = 0; b_cyc = 0;
    prev_stall = 1'b0; prev_dout = '0; finished = 1'b0;
    strt = 1'b1;
    rdy  = (mode == 0);
    for (int k = 1; k < 2000; k++) begin
      @(negedge clk);
      strt = (k == strt_a) || (k == strt_b);
      rdy  = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
      if (prev_stall) begin
        chk("stall_vld", 36'(vld), 36'd1);
        chk("stall_dout", 36'(dout), 36'(prev_dout));
      end
      prev_stall = vld && !rdy;
      prev_dout  = dout;
      if (busy) b_cyc++;
      if (tx_done) begin
        n_p++;
        d_cyc = k;
      end
      if (vld && rdy) begin
        $display("xfer %0d cycle %0d addr %0d dout %05h", n_x, k, addr_rd, dout);
        if (n_x < 64) begin
          chk("dout", 36'(dout), 36'(exp_v[n_x]));
          chk("addr_rd", 36'(addr_rd), 36'(n_x / 16));
          if (mode == 0) chk("xfer_cycle", 36'(k), 36'(3 + (n_x / 16) * 18 + n_x % 16));
        end
        n_x++;
        if (abort_after > 0 && n_x == abort_after) begin
          rst_n = 1'b0;
          #1;
          chk("rst_addr_rd", 36'(addr_rd), 36'd0);
          chk("rst_dout", 36'(dout), 36'd0);
          chk("rst_vld", 36'(vld), 36'd0);
          chk("rst_tx_done", 36'(tx_done), 36'd0);
          chk("rst_busy", 36'(busy), 36'd0);
          for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (j == 3) rst_n = 1'b1;
            if (tx_done) n_p++;
            if (busy) b_cyc++;
          end
          strt = 1'b0;
          return;
        end
      end
      if (n_p > 0 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    strt = 1'b0;
    chk("stream_finished", 36'(finished), 36'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; strt = 1'b0; rdy = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int l = 0; l < 16; l++) mem[b][l] = 36'h0_0000_0A00;
    repeat (3) @(negedge clk);
    chk("reset_addr_rd", 36'(addr_rd), 36'd0);
    chk("reset_dout", 36'(dout), 36'd0);
    chk("reset_vld", 36'(vld), 36'd0);
    chk("reset_tx_done", 36'(tx_done), 36'd0);
    chk("reset_busy", 36'(busy), 36'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Constant word: 0xA00 >>> 8 = 0xA on every transfer.
    for (int n = 0; n < 64; n++) exp_v[n] = 18'h0000A;
    run_stream(0, 0, -1, -1, xfers, done_cyc, pulses, busy_cyc);
    chk("const_xfers", 36'(xfers), 36'd64);
    chk("const_done_cycle", 36'(done_cyc), 36'd73);
    chk("const_done_pulses", 36'(pulses), 36'd1);
    chk("const_busy_cycles", 36'(busy_cyc), 36'd73);
    repeat (2) @(negedge clk);

    // Ordering: dout = bank*16 + lane.
    fill_order();
    run_stream(0, 0, -1, -1, xfers, done_cyc, pulses, busy_cyc);
    chk("order_xfers", 36'(xfers), 36'd64);
    chk("order_done_cycle", 36'(done_cyc), 36'd73);
    repeat (2) @(negedge clk);

    // Saturation and clamp corners in bank 0 lanes 0..7.
    for (int l = 0; l < 8; l++) begin
      mem[0][l] = sat_in[l];
      exp_v[l]  = sat_exp[l];
    end
    run_stream(0, 0, -1, -1, xfers, done_cyc, pulses, busy_cyc);
    chk("sat_xfers", 36'(xfers), 36'd64);
    chk("sat_done_pulses", 36'(pulses), 36'd1);
    repeat (2) @(negedge clk);

    // Backpressure at 30 % ready.
    fill_order();
    run_stream(1, 0, -1, -1, xfers, done_cyc, pulses, busy_cyc);
    chk("bp_xfers", 36'(xfers), 36'd64);
    chk("bp_done_pulses", 36'(pulses), 36'd1);
    repeat (2) @(negedge clk);

    // Reset after the 20th transfer: no tx_done, outputs back to zero.
    run_stream(0, 20, -1, -1, xfers, done_cyc, pulses, busy_cyc);
    chk("abort_xfers", 36'(xfers), 36'd20);
    chk("abort_no_done", 36'(pulses), 36'd0);
    chk("abort_idle_busy", 36'(busy), 36'd0);

    // Fresh start; strt during SEND (cycle 10) and in DONE (cycle 73) ignored.
    run_stream(0, 0, 10, 73, xfers, done_cyc, pulses, busy_cyc);
    chk("retrig_xfers", 36'(xfers), 36'd64);
    chk("retrig_done_cycle", 36'(done_cyc), 36'd73);
    chk("retrig_done_pulses", 36'(pulses), 36'd1);
    chk("retrig_busy_cycles", 36'(busy_cyc), 36'd73);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("post_done_idle", 36'(busy), 36'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
